// File: rtl/md5_crack_pkg.sv
// Shared types and constants for the MD5 cracker run-control block.
package md5_crack_pkg;
  localparam int DIGEST_W = 128;
  localparam int A_HI = 127, A_LO = 96;
  localparam int B_HI = 95,  B_LO = 64;
  localparam int C_HI = 63,  C_LO = 32;
  localparam int D_HI = 31,  D_LO = 0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/hit_fifo.sv
// First-word-fall-through hit buffer; a push into a full FIFO is dropped
// unless a pop happens in the same cycle, and the drop is remembered.
module hit_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o,
  output logic         overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          empty, full, pop_ok, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty;
  assign push_ok = push_i && (!full || pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q | (push_i && !push_ok);
    if (push_ok) wr_d = wr_q + PW'(1);
    if (pop_ok)  rd_d = rd_q + PW'(1);
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign valid_o    = !empty;
  assign dout_o     = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign overflow_o = ovf_q;
endmodule

// File: rtl/md5_crack_controller.sv
// Run control between guess generator and MD5 pipeline: carries each guess
// alongside the hash pipeline and captures the guesses whose digest matches.
module md5_crack_controller
  import md5_crack_pkg::*;
#(
  parameter int GUESS_W      = 128,
  parameter int PIPE_LATENCY = 64,
  parameter int HIT_DEPTH    = 4,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                target_we,
  input  logic [DIGEST_W-1:0] target_in,
  input  logic                start,
  input  logic                stop_on_hit,
  input  logic [GUESS_W-1:0]  guess,
  input  logic                guess_valid,
  input  logic                gen_done,
  input  logic [DIGEST_W-1:0] hash,
  output logic                gen_run,
  output logic                gen_clear,
  output logic                busy,
  output logic                found,
  output logic                exhausted,
  output logic [CNT_W-1:0]    hit_count,
  output logic                hit_valid,
  output logic [GUESS_W-1:0]  hit_guess,
  input  logic                hit_rd,
  output logic                hit_overflow
);
  localparam int DCW = $clog2(PIPE_LATENCY + 2);

  state_e                  state_q, state_d;
  logic [DIGEST_W-1:0]     target_q;
  logic                    sohit_q, found_q, exh_q, gclr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DCW-1:0]          drain_q, drain_d;
  logic [PIPE_LATENCY-1:0] dl_vld_q, dl_vld_d;
  logic [GUESS_W-1:0]      dl_guess_q [PIPE_LATENCY];
  logic                    idle_like, start_ok, hit_d, halt, exh_set;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign gen_run   = (state_q == S_RUN);
  assign start_ok  = start && idle_like;
  // Entries still in flight after a halt are ignored by gating with busy.
  assign hit_d     = busy && dl_vld_q[PIPE_LATENCY-1] && (hash == target_q);
  assign halt      = hit_d && sohit_q;

  always_comb begin
    dl_vld_d    = dl_vld_q << 1;
    dl_vld_d[0] = guess_valid && gen_run;
    if (start_ok) dl_vld_d = '0;
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    exh_set = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (halt) state_d = S_DONE;
        else if (gen_done) begin
          state_d = S_DRAIN;
          drain_d = DCW'(PIPE_LATENCY + 1);
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - DCW'(1);
        if (halt) state_d = S_DONE;
        else if (drain_q == DCW'(1)) begin
          state_d = S_DONE;
          exh_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      sohit_q  <= 1'b0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      cnt_q    <= '0;
      gclr_q   <= 1'b0;
      drain_q  <= '0;
      dl_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      dl_vld_q <= dl_vld_d;
      gclr_q   <= start_ok;
      if (target_we && idle_like) target_q <= target_in;
      if (start_ok) begin
        sohit_q <= stop_on_hit;
        found_q <= 1'b0;
        exh_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        if (hit_d) begin
          found_q <= 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
        end
        if (exh_set) exh_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    dl_guess_q[0] <= guess;
    for (int i = 1; i < PIPE_LATENCY; i++) dl_guess_q[i] <= dl_guess_q[i-1];
  end

  hit_fifo #(.W(GUESS_W), .DEPTH(HIT_DEPTH)) u_hit_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (start_ok),
    .push_i     (hit_d),
    .din_i      (dl_guess_q[PIPE_LATENCY-1]),
    .pop_i      (hit_rd),
    .valid_o    (hit_valid),
    .dout_o     (hit_guess),
    .overflow_o (hit_overflow)
  );

  assign gen_clear = gclr_q;
  assign found     = found_q;
  assign exhausted = exh_q;
  assign hit_count = cnt_q;
endmodule

// File: tb/tb_md5_crack_controller.sv
// Randomized scenario bench with a cycle-level reference model of run control.
module tb_md5_crack_controller;
  localparam int GW = 128, L = 16, D = 4, CW = 3;
  localparam logic [127:0] MD5_ABC = 128'h900150983cd24fb0d6963f7d28e17f72;

  logic clk = 1'b0;
  logic reset, target_we, start, stop_on_hit, guess_valid, gen_done, hit_rd;
  logic [127:0] target_in, hash;
  logic [GW-1:0] guess, hit_guess;
  logic gen_run, gen_clear, busy, found, exhausted, hit_valid, hit_overflow;
  logic [CW-1:0] hit_count;

  int vectors = 0, miscompares = 0;

  logic [127:0] gq[$];
  bit           vq[$];
  logic [127:0] mq[$];
  bit           movf;

  always #5 clk = ~clk;

  md5_crack_controller #(.GUESS_W(GW), .PIPE_LATENCY(L), .HIT_DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .target_we(target_we), .target_in(target_in),
    .start(start), .stop_on_hit(stop_on_hit), .guess(guess), .guess_valid(guess_valid),
    .gen_done(gen_done), .hash(hash), .gen_run(gen_run), .gen_clear(gen_clear),
    .busy(busy), .found(found), .exhausted(exhausted), .hit_count(hit_count),
    .hit_valid(hit_valid), .hit_guess(hit_guess), .hit_rd(hit_rd),
    .hit_overflow(hit_overflow)
  );

  // Stand-in hash: "abc" gets its real MD5, everything else a cheap keyed digest.
  function automatic logic [127:0] digest_of(input logic [127:0] g);
    if (g == 128'h616263) return MD5_ABC;
    return {4{g[31:0] ^ 32'h5a5ac3c3}};
  endfunction

  logic [127:0] sh [L];
  always @(posedge clk) begin
    sh[0] <= digest_of(guess);
    for (int i = 1; i < L; i++) sh[i] <= sh[i-1];
  end
  assign hash = sh[L-1];

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input bit sohit, input bit ld, input logic [127:0] t);
    start = 1'b1; stop_on_hit = sohit; target_we = ld; target_in = t;
    tick();
    start = 1'b0; target_we = 1'b0;
    mq.delete(); movf = 1'b0;
  endtask

  task automatic run_scenario(input string tn, input bit sohit, input logic [127:0] tgt,
                              input int pop_cyc, input int we_cyc, input logic [127:0] we_t);
    int n, first, end_c, nh, exp_cnt, j;
    bit hitf[$];
    n = gq.size(); first = -1;
    for (int k = 0; k < n; k++) begin
      hitf.push_back(vq[k] && digest_of(gq[k]) == tgt);
      if (hitf[k] && first < 0) first = k;
    end
    end_c = (sohit && first >= 0) ? first + L + 1 : n + L + 1;
    for (int c = 0; c <= end_c + 1; c++) begin
      nh = 0;
      for (int k = 0; k < n; k++) if (hitf[k] && k + L + 1 <= c && k + L + 1 <= end_c) nh++;
      exp_cnt = (nh > 7) ? 7 : nh;
      vectors += 8;
      if (busy !== (c < end_c)) begin miscompares++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", tn, c, busy, (c < end_c)); end
      if (gen_run !== (c < n && c < end_c)) begin miscompares++;
        $display("FAIL %s gen_run cyc=%0d got=%b exp=%b", tn, c, gen_run, (c < n && c < end_c)); end
      if (gen_clear !== (c == 0)) begin miscompares++;
        $display("FAIL %s gen_clear cyc=%0d got=%b exp=%b", tn, c, gen_clear, (c == 0)); end
      if (found !== (nh > 0)) begin miscompares++;
        $display("FAIL %s found cyc=%0d got=%b exp=%b", tn, c, found, (nh > 0)); end
      if (hit_count !== CW'(exp_cnt)) begin miscompares++;
        $display("FAIL %s hit_count cyc=%0d got=%0d exp=%0d", tn, c, hit_count, exp_cnt); end
      if (exhausted !== (c >= end_c && !(sohit && first >= 0))) begin miscompares++;
        $display("FAIL %s exhausted cyc=%0d got=%b", tn, c, exhausted); end
      if (hit_overflow !== movf) begin miscompares++;
        $display("FAIL %s hit_overflow cyc=%0d got=%b exp=%b", tn, c, hit_overflow, movf); end
      if (hit_valid !== (mq.size() > 0)) begin miscompares++;
        $display("FAIL %s hit_valid cyc=%0d got=%b exp=%b", tn, c, hit_valid, (mq.size() > 0)); end
      if (mq.size() > 0) begin
        vectors++;
        if (hit_guess !== mq[0]) begin miscompares++;
          $display("FAIL %s hit_guess cyc=%0d got=%h exp=%h", tn, c, hit_guess, mq[0]); end
      end
      guess_valid = 1'b0; gen_done = 1'b0;
      if (c < n) begin guess = gq[c]; guess_valid = vq[c]; gen_done = (c == n - 1); end
      hit_rd = (c == pop_cyc);
      target_we = (c == we_cyc); target_in = we_t;
      if (hit_rd && mq.size() > 0) void'(mq.pop_front());
      j = c - L;
      if (j >= 0 && j < n && hitf[j] && c + 1 <= end_c) begin
        if (mq.size() < D) mq.push_back(gq[j]); else movf = 1'b1;
      end
      tick();
      guess_valid = 1'b0; gen_done = 1'b0; hit_rd = 1'b0; target_we = 1'b0;
    end
  endtask

  task automatic pop_all(input string tn);
    while (mq.size() > 0) begin
      vectors++;
      if (hit_valid !== 1'b1 || hit_guess !== mq[0]) begin miscompares++;
        $display("FAIL %s pop got=%b/%h exp=1/%h", tn, hit_valid, hit_guess, mq[0]); end
      hit_rd = 1'b1; tick(); hit_rd = 1'b0;
      void'(mq.pop_front());
    end
    hit_rd = 1'b1; tick(); hit_rd = 1'b0;
    vectors++;
    if (hit_valid !== 1'b0 || hit_overflow !== movf) begin miscompares++;
      $display("FAIL %s empty_pop got=%b/%b exp=0/%b", tn, hit_valid, hit_overflow, movf); end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    vectors++;
    if ({gen_run, gen_clear, busy, found, exhausted, hit_valid, hit_overflow} !== 7'b0 ||
        hit_count !== '0 || hit_guess !== '0) begin miscompares++;
      $display("FAIL reset outputs got=%b cnt=%0d", {gen_run, gen_clear, busy, found,
               exhausted, hit_valid, hit_overflow}, hit_count); end
  endtask

  task automatic test_stop_hit();
    gq.delete(); vq.delete();
    for (int k = 0; k < 40; k++) begin gq.push_back(rnd128()); vq.push_back(1'b1); end
    gq[5] = 128'h616263;
    do_start(1'b1, 1'b1, MD5_ABC);
    run_scenario("stop_hit", 1'b1, MD5_ABC, -1, -1, '0);
    vectors++;
    if (hit_guess !== 128'h616263 || hit_count !== CW'(1)) begin miscompares++;
      $display("FAIL stop_hit head got=%h cnt=%0d exp=616263 cnt=1", hit_guess, hit_count); end
    pop_all("stop_hit");
  endtask

  task automatic test_exhaustive();
    logic [127:0] t;
    t = digest_of(rnd128());
    gq.delete(); vq.delete();
    for (int k = 0; k < 100; k++) begin gq.push_back(rnd128()); vq.push_back($urandom_range(0, 3) != 0); end
    do_start(1'b0, 1'b1, t);
    run_scenario("exhaustive", 1'b0, t, -1, -1, '0);
    pop_all("exhaustive");
  endtask

  task automatic test_overflow();
    logic [127:0] x;
    x = rnd128();
    gq.delete(); vq.delete();
    for (int k = 0; k < 30; k++) begin gq.push_back(rnd128()); vq.push_back($urandom_range(0, 3) != 0); end
    foreach (gq[k]) if (k == 2 || k == 6 || k == 9 || k == 15 || k == 20 || k == 27) begin
      gq[k] = {rnd128() >> 32, x[31:0]}; vq[k] = 1'b1; end
    gq[4] = x; vq[4] = 1'b0;
    gq[12] = x; vq[12] = 1'b0;
    do_start(1'b0, 1'b1, digest_of(x));
    run_scenario("overflow", 1'b0, digest_of(x), -1, -1, '0);
    pop_all("overflow");
  endtask

  task automatic test_drain_hit(input bit sohit);
    logic [127:0] x;
    x = rnd128();
    gq.delete(); vq.delete();
    for (int k = 0; k < 20; k++) begin gq.push_back(rnd128()); vq.push_back(1'b1); end
    gq[19] = x;
    do_start(sohit, 1'b1, digest_of(x));
    run_scenario(sohit ? "drain_hit_stop" : "drain_hit", sohit, digest_of(x), -1, -1, '0);
    pop_all("drain_hit");
  endtask

  task automatic test_push_pop_full();
    logic [127:0] x;
    x = rnd128();
    gq.delete(); vq.delete();
    for (int k = 0; k < 15; k++) begin
      gq.push_back((k < 4 || k == 10) ? {rnd128() >> 32, x[31:0]} : rnd128());
      vq.push_back(1'b1);
    end
    do_start(1'b0, 1'b1, digest_of(x));
    run_scenario("push_pop_full", 1'b0, digest_of(x), 10 + L, -1, '0);
    pop_all("push_pop_full");
  endtask

  task automatic test_saturate();
    logic [127:0] x;
    x = rnd128();
    gq.delete(); vq.delete();
    for (int k = 0; k < 12; k++) begin
      gq.push_back((k < 10) ? {rnd128() >> 32, x[31:0]} : rnd128());
      vq.push_back(1'b1);
    end
    do_start(1'b0, 1'b1, digest_of(x));
    run_scenario("saturate", 1'b0, digest_of(x), -1, -1, '0);
    pop_all("saturate");
  endtask

  task automatic test_target_we_busy();
    logic [127:0] a, b;
    a = rnd128(); b = rnd128();
    gq.delete(); vq.delete();
    for (int k = 0; k < 20; k++) begin gq.push_back(rnd128()); vq.push_back(1'b1); end
    gq[12] = a; gq[14] = b;
    do_start(1'b0, 1'b1, digest_of(a));
    run_scenario("target_we_busy", 1'b0, digest_of(a), -1, 3, digest_of(b));
    pop_all("target_we_busy");
    do_start(1'b0, 1'b1, digest_of(b));
    run_scenario("target_we_done", 1'b0, digest_of(b), -1, -1, '0);
    pop_all("target_we_done");
  endtask

  task automatic test_reset_midrun();
    logic [127:0] x;
    x = rnd128();
    do_start(1'b0, 1'b1, digest_of(x));
    for (int c = 0; c < 25; c++) begin
      guess = (c == 2) ? x : rnd128(); guess_valid = 1'b1;
      tick();
    end
    guess_valid = 1'b0;
    vectors++;
    if (found !== 1'b1 || busy !== 1'b1 || hit_valid !== 1'b1) begin miscompares++;
      $display("FAIL midrun pre-reset got found=%b busy=%b hv=%b exp=1 1 1", found, busy, hit_valid); end
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++;
    if ({gen_run, gen_clear, busy, found, exhausted, hit_valid, hit_overflow} !== 7'b0 ||
        hit_count !== '0 || hit_guess !== '0) begin miscompares++;
      $display("FAIL midrun reset outputs got=%b cnt=%0d", {gen_run, gen_clear, busy, found,
               exhausted, hit_valid, hit_overflow}, hit_count); end
    tick();
    vectors++;
    if (busy !== 1'b0 || found !== 1'b0) begin miscompares++;
      $display("FAIL midrun settle got busy=%b found=%b exp=0 0", busy, found); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; target_we = 1'b0; start = 1'b0; stop_on_hit = 1'b0;
    guess_valid = 1'b0; gen_done = 1'b0; hit_rd = 1'b0;
    target_in = '0; guess = '0; movf = 1'b0;
    tick();
    test_reset();
    test_stop_hit();
    test_exhaustive();
    test_overflow();
    test_drain_hit(1'b0);
    test_drain_hit(1'b1);
    test_push_pop_full();
    test_saturate();
    test_target_we_busy();
    test_reset_midrun();
    test_stop_hit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
